// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizes for the common data bus arbiter.
// Defines the FIFO entry layout and the round-robin pick helper.
package cdb_arbiter_pkg;

  localparam int CDB_FIFO_SIZE   = 2;
  localparam int CDB_FIFO_SIZE_W = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
  } cdb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // Alternate on contention; otherwise take
  // whichever source has something.
  function automatic logic rr_pick(
    input logic ne0,
    input logic ne1,
    input logic last
  );
    logic g;
    g = ne1;
    if (ne0 && ne1) g = ~last;
    return g;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Single-clock circular buffer of {addr,val} result entries.
// Ports: clk_in/rst_in/rdy_in, push/pop/clear, din/dout, empty/full.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_SIZE,
  parameter int W     = CDB_FIFO_SIZE_W
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  cdb_entry_t din,
  output cdb_entry_t dout,
  output logic       empty,
  output logic       full
);

  localparam logic [W:0] LP_FULL = (W+1)'(DEPTH);

  cdb_entry_t   r_mem [DEPTH];
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [W:0]   r_count;

  logic w_act;
  logic w_push;
  logic w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == LP_FULL);
  assign dout  = r_mem[r_head];

  assign w_act  = rdy_in && !clear;
  assign w_push = w_act && push && !full;
  assign w_pop  = w_act && pop && !empty;

  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push) begin
      r_mem[r_tail] <= din;
    end
  end

  // Pointers are W bits wide over a power-of-two
  // depth, so plain increment wraps to 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between ALU (0) and LSB (1).
// Ports: src0/src1 valid/addr/val/ready in, registered cdb_* broadcast out.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = CDB_FIFO_SIZE,
  parameter int FIFO_W     = CDB_FIFO_SIZE_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        src0_valid,
  input  logic [31:0] src0_addr,
  input  logic [31:0] src0_val,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [31:0] src1_addr,
  input  logic [31:0] src1_val,
  output logic        src1_ready,
  output logic        cdb_active,
  output logic [31:0] cdb_addr,
  output logic [31:0] cdb_val,
  output logic        cdb_src
);

  logic        r_active;
  logic [31:0] r_addr;
  logic [31:0] r_val;
  logic        r_src;
  logic        r_last;

  cdb_entry_t w_din0;
  cdb_entry_t w_din1;
  cdb_entry_t w_dout0;
  cdb_entry_t w_dout1;
  cdb_entry_t w_head;
  logic       w_empty0;
  logic       w_empty1;
  logic       w_full0;
  logic       w_full1;
  logic       w_push0;
  logic       w_push1;
  logic       w_pop0;
  logic       w_pop1;
  logic       w_any;
  logic       w_grant;
  logic       w_go;

  assign src0_ready = !w_full0;
  assign src1_ready = !w_full1;

  assign w_go    = rdy_in && !flush;
  assign w_push0 = src0_valid && src0_ready && w_go;
  assign w_push1 = src1_valid && src1_ready && w_go;

  assign w_din0 = '{addr: src0_addr, val: src0_val};
  assign w_din1 = '{addr: src1_addr, val: src1_val};

  // Arbitration looks only at registered FIFO
  // state, so a result never bypasses its FIFO.
  assign w_any   = !w_empty0 || !w_empty1;
  assign w_grant = rr_pick(!w_empty0, !w_empty1, r_last);
  assign w_pop0  = w_go && w_any && !w_grant;
  assign w_pop1  = w_go && w_any && w_grant;
  assign w_head  = w_grant ? w_dout1 : w_dout0;

  cdb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo0 (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .push   (w_push0),
    .pop    (w_pop0),
    .clear  (flush),
    .din    (w_din0),
    .dout   (w_dout0),
    .empty  (w_empty0),
    .full   (w_full0)
  );

  cdb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo1 (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .push   (w_push1),
    .pop    (w_pop1),
    .clear  (flush),
    .din    (w_din1),
    .dout   (w_dout1),
    .empty  (w_empty1),
    .full   (w_full1)
  );

  // last starts at LSB so the ALU wins the
  // first contention after reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_active <= 1'b0;
      r_addr   <= '0;
      r_val    <= '0;
      r_src    <= SRC_ALU;
      r_last   <= SRC_LSB;
    end else if (rdy_in) begin
      if (flush) begin
        r_active <= 1'b0;
      end else if (w_any) begin
        r_active <= 1'b1;
        r_addr   <= w_head.addr;
        r_val    <= w_head.val;
        r_src    <= w_grant;
        r_last   <= w_grant;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign cdb_active = r_active;
  assign cdb_addr   = r_addr;
  assign cdb_val    = r_val;
  assign cdb_src    = r_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter.
// Directed pushes queue expected broadcasts; a monitor pops and compares.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        src0_valid;
  logic [31:0] src0_addr;
  logic [31:0] src0_val;
  logic        src0_ready;
  logic        src1_valid;
  logic [31:0] src1_addr;
  logic [31:0] src1_val;
  logic        src1_ready;
  logic        cdb_active;
  logic [31:0] cdb_addr;
  logic [31:0] cdb_val;
  logic        cdb_src;

  typedef struct {
    logic        src;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic edge_rdy = 1'b0;

  cdb_arbiter #(
    .FIFO_DEPTH (2),
    .FIFO_W     (1)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush      (flush),
    .src0_valid (src0_valid),
    .src0_addr  (src0_addr),
    .src0_val   (src0_val),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_addr  (src1_addr),
    .src1_val   (src1_val),
    .src1_ready (src1_ready),
    .cdb_active (cdb_active),
    .cdb_addr   (cdb_addr),
    .cdb_val    (cdb_val),
    .cdb_src    (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) edge_rdy <= rdy_in;

  task automatic chk(
    input string      n,
    input logic [64:0] act,
    input logic [64:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // A fresh broadcast appears after every edge taken
  // with rdy_in high while cdb_active is set.
  always @(negedge clk_in) begin
    if (cdb_active && edge_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bcast_extra got %0d:%h want none",
                 cdb_src, cdb_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcast", {cdb_src, cdb_addr, cdb_val},
            {e.src, e.addr, e.val});
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic exp_push(
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] v
  );
    exp_t e;
    e.src  = s;
    e.addr = a;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drv0(input logic v, input logic [31:0] a);
    src0_valid = v;
    src0_addr  = a;
    src0_val   = a + 32'h1;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a);
    src1_valid = v;
    src1_addr  = a;
    src1_val   = a + 32'h2;
  endtask

  task automatic idle();
    drv0(1'b0, 32'h0);
    drv1(1'b0, 32'h0);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    step();
    step();
    chk("rst_active", 65'(cdb_active), 65'(0));
    chk("rst_addr_val", 65'({cdb_addr, cdb_val}), 65'(0));
    chk("rst_src", 65'(cdb_src), 65'(0));
    chk("rst_ready", 65'({src0_ready, src1_ready}), 65'(3));
    rst_in = 1'b0;
  endtask

  int i0;
  int i1;

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();

    // Single ALU result: visible only after the second edge.
    do_reset();
    src0_valid = 1'b1;
    src0_addr  = 32'h100;
    src0_val   = 32'h1;
    exp_push(1'b0, 32'h100, 32'h1);
    step();
    idle();
    chk("t1_lat_e0", 65'(cdb_active), 65'(0));
    step();
    chk("t1_lat_e1", 65'(cdb_active), 65'(1));
    step();
    chk("t1_lat_e2", 65'(cdb_active), 65'(0));

    // Contention from reset: ALU first.
    do_reset();
    src0_valid = 1'b1;
    src0_addr  = 32'h200;
    src0_val   = 32'hA;
    src1_valid = 1'b1;
    src1_addr  = 32'h300;
    src1_val   = 32'hB;
    exp_push(1'b0, 32'h200, 32'hA);
    exp_push(1'b1, 32'h300, 32'hB);
    step();
    idle();
    repeat (3) step();

    // Fairness: continuous pushes, strict alternation, no gaps.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_push(1'b0, 32'hA00 + 32'(4 * k), 32'hA01 + 32'(4 * k));
      exp_push(1'b1, 32'hB00 + 32'(4 * k), 32'hB02 + 32'(4 * k));
    end
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 10; k++) begin
      logic a0;
      logic a1;
      drv0(i0 < 4, 32'hA00 + 32'(4 * i0));
      drv1(i1 < 4, 32'hB00 + 32'(4 * i1));
      a0 = src0_valid && src0_ready;
      a1 = src1_valid && src1_ready;
      step();
      if (a0) i0++;
      if (a1) i1++;
      if (k >= 1 && k <= 8)
        chk("t3_nogap", 65'(cdb_active), 65'(1));
      if (k == 9)
        chk("t3_drain", 65'(cdb_active), 65'(0));
    end
    idle();
    chk("t3_accepted", 65'({i0[3:0], i1[3:0]}), 65'(8'h44));

    // Backpressure: ALU FIFO fills while LSB holds the bus.
    do_reset();
    drv0(1'b1, 32'h0C);
    exp_push(1'b0, 32'h0C, 32'h0D);
    step();
    idle();
    step();
    exp_push(1'b1, 32'h80, 32'h82);
    exp_push(1'b0, 32'h10, 32'h11);
    exp_push(1'b1, 32'h84, 32'h86);
    exp_push(1'b0, 32'h14, 32'h15);
    exp_push(1'b0, 32'h18, 32'h19);
    drv0(1'b1, 32'h10);
    drv1(1'b1, 32'h80);
    step();
    drv0(1'b1, 32'h14);
    drv1(1'b1, 32'h84);
    step();
    chk("t4_full_rdy", 65'(src0_ready), 65'(0));
    drv0(1'b1, 32'h18);
    drv1(1'b0, 32'h0);
    step();
    chk("t4_after_pop", 65'(src0_ready), 65'(1));
    step();
    idle();
    repeat (5) step();

    // Flush with buffered entries and a same-cycle push.
    do_reset();
    exp_push(1'b0, 32'h600, 32'h601);
    drv0(1'b1, 32'h600);
    drv1(1'b1, 32'h700);
    step();
    drv0(1'b1, 32'h604);
    drv1(1'b1, 32'h704);
    step();
    chk("t5_lsb_full", 65'(src1_ready), 65'(0));
    drv0(1'b1, 32'h608);
    drv1(1'b1, 32'h400);
    flush = 1'b1;
    step();
    idle();
    chk("t5_active", 65'(cdb_active), 65'(0));
    chk("t5_ready", 65'({src0_ready, src1_ready}), 65'(3));
    chk("t5_hold", 65'({cdb_src, cdb_addr}), 65'(32'h600));
    repeat (3) step();
    chk("t5_quiet", 65'(cdb_active), 65'(0));
    exp_push(1'b1, 32'h710, 32'h712);
    exp_push(1'b0, 32'h610, 32'h611);
    drv0(1'b1, 32'h610);
    drv1(1'b1, 32'h710);
    step();
    idle();
    repeat (4) step();

    // Pause with a broadcast on the bus.
    do_reset();
    exp_push(1'b0, 32'h500, 32'h501);
    exp_push(1'b0, 32'h504, 32'h505);
    drv0(1'b1, 32'h500);
    step();
    drv0(1'b1, 32'h504);
    step();
    drv0(1'b0, 32'h0);
    drv1(1'b1, 32'h900);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_frozen", 65'({cdb_active, cdb_addr}),
          65'({1'b1, 32'h500}));
    end
    idle();
    rdy_in = 1'b1;
    step();
    chk("t6_resume", 65'({cdb_active, cdb_addr}),
        65'({1'b1, 32'h504}));
    step();
    chk("t6_end", 65'(cdb_active), 65'(0));
    repeat (2) step();

    // Reset mid-stream discards what is buffered.
    do_reset();
    exp_push(1'b0, 32'h800, 32'h801);
    drv0(1'b1, 32'h800);
    step();
    drv0(1'b1, 32'h804);
    step();
    do_reset();
    repeat (4) step();
    chk("t7_quiet", 65'(cdb_active), 65'(0));

    chk("sb_empty", 65'(sb.size()), 65'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
